// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; the master side holds the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 64
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core (r0)
// and the debug/loader port (r1), with a one-cycle registered read-response path.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [15:0]   conflict_cnt
);

  logic        last_q, last_d;
  logic        pend_rd_q, pend_rd_d;
  logic        pend_id_q, pend_id_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic gnt0, gnt1, both;

  assign both = bus.r0_req & bus.r1_req;

  // Grants are gated by rst_n so outputs go quiet the moment reset asserts.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (both) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.r0_req;
        gnt1 = bus.r1_req;
      end
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt0) begin
      bus.mem_we    = bus.r0_we;
      bus.mem_addr  = bus.r0_addr;
      bus.mem_wdata = bus.r0_wdata;
    end else if (gnt1) begin
      bus.mem_we    = bus.r1_we;
      bus.mem_addr  = bus.r1_addr;
      bus.mem_wdata = bus.r1_wdata;
    end
  end

  assign bus.mem_en    = gnt0 | gnt1;
  assign bus.r0_gnt    = gnt0;
  assign bus.r1_gnt    = gnt1;
  assign bus.r0_rvalid = pend_rd_q & ~pend_id_q;
  assign bus.r1_rvalid = pend_rd_q & pend_id_q;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_rdata : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_rdata : '0;
  assign conflict_cnt  = conflict_cnt_q;

  always_comb begin
    last_d         = last_q;
    pend_id_d      = pend_id_q;
    pend_rd_d      = 1'b0;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt0) begin
      last_d    = 1'b0;
      pend_id_d = 1'b0;
      pend_rd_d = ~bus.r0_we;
    end else if (gnt1) begin
      last_d    = 1'b1;
      pend_id_d = 1'b1;
      pend_rd_d = ~bus.r1_we;
    end
    if (both && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // last resets to 1 so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q         <= 1'b1;
      pend_rd_q      <= 1'b0;
      pend_id_q      <= 1'b0;
      conflict_cnt_q <= 16'd0;
    end else begin
      last_q         <= last_d;
      pend_rd_q      <= pend_rd_d;
      pend_id_q      <= pend_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter; requesters are command queues and the
// expected behaviour comes from a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [63:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] conflict_cnt;

  dmem_arbiter_if #(.AW(8), .DW(64)) bus ();

  dmem_arbiter #(.AW(8), .DW(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural memory on the far side of the arbiter.
  logic [63:0] mem_arr [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  cmd_t q0[$];
  cmd_t q1[$];

  // Reference model state
  logic [63:0] ref_mem [256];
  int          m_last;
  bit          m_pend;
  int          m_pend_id;
  logic [63:0] m_pend_data;
  int          m_cnt;
  int          e_win;
  bit          quiet;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_last = 1; m_pend = 0; m_pend_id = 0; m_pend_data = '0; m_cnt = 0;
  endtask

  task automatic drive();
    bus.r0_req   = (q0.size() > 0);
    bus.r0_we    = (q0.size() > 0) ? q0[0].we    : 1'b0;
    bus.r0_addr  = (q0.size() > 0) ? q0[0].addr  : 8'h0;
    bus.r0_wdata = (q0.size() > 0) ? q0[0].wdata : 64'h0;
    bus.r1_req   = (q1.size() > 0);
    bus.r1_we    = (q1.size() > 0) ? q1[0].we    : 1'b0;
    bus.r1_addr  = (q1.size() > 0) ? q1[0].addr  : 8'h0;
    bus.r1_wdata = (q1.size() > 0) ? q1[0].wdata : 64'h0;
  endtask

  // Winner: sole requester, or on a tie whoever was not served last; -1 for none.
  task automatic eval_check();
    cmd_t c;
    bit   q0v, q1v;
    q0v = (q0.size() > 0);
    q1v = (q1.size() > 0);
    e_win = -1;
    if (rst_n) begin
      if (q0v && q1v)  e_win = 1 - m_last;
      else if (q0v)    e_win = 0;
      else if (q1v)    e_win = 1;
    end
    c.we = 1'b0; c.addr = '0; c.wdata = '0;
    if (e_win == 0) c = q0[0];
    if (e_win == 1) c = q1[0];
    if (!quiet) begin
      chk("r0_gnt", 64'(bus.r0_gnt), 64'(e_win == 0));
      chk("r1_gnt", 64'(bus.r1_gnt), 64'(e_win == 1));
      chk("mem_en", 64'(bus.mem_en), 64'(e_win >= 0));
      chk("mem_we", 64'(bus.mem_we), 64'(c.we));
      chk("mem_addr", 64'(bus.mem_addr), 64'(c.addr));
      chk("mem_wdata", bus.mem_wdata, c.wdata);
      chk("r0_rvalid", 64'(bus.r0_rvalid), 64'(m_pend && m_pend_id == 0));
      chk("r1_rvalid", 64'(bus.r1_rvalid), 64'(m_pend && m_pend_id == 1));
      chk("r0_rdata", bus.r0_rdata, (m_pend && m_pend_id == 0) ? m_pend_data : 64'h0);
      chk("r1_rdata", bus.r1_rdata, (m_pend && m_pend_id == 1) ? m_pend_data : 64'h0);
      chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    end
  endtask

  task automatic edge_update();
    cmd_t c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (q0.size() > 0 && q1.size() > 0 && m_cnt < 65535) m_cnt++;
    m_pend = 0;
    if (e_win >= 0) begin
      if (e_win == 0) c = q0.pop_front();
      else            c = q1.pop_front();
      m_last = e_win;
      if (c.we) ref_mem[c.addr] = c.wdata;
      else begin
        m_pend      = 1;
        m_pend_id   = e_win;
        m_pend_data = ref_mem[c.addr];
      end
    end
  endtask

  task automatic cyc();
    drive();
    @(negedge clk);
    eval_check();
    @(posedge clk);
    edge_update();
    #1;
  endtask

  task automatic push(input int id, input logic we, input logic [7:0] addr, input logic [63:0] wd);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wd;
    if (id == 0) q0.push_back(c);
    else         q1.push_back(c);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cycles) begin
      cyc();
      n++;
    end
    chk("drain_bound", 64'(q0.size() + q1.size()), 64'd0);
    cyc();
  endtask

  initial begin
    int cnt0;
    quiet = 0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    bus.mem_rdata = '0;
    model_reset();

    // Reset held with both requesters asking: nothing may be granted.
    push(0, 1'b0, 8'd9, 64'h0);
    push(1, 1'b0, 8'd10, 64'h0);
    rst_n = 1'b0;
    cyc();
    cyc();
    #1 rst_n = 1'b1;
    cyc();
    chk("first_tie_to_r0", 64'(m_last), 64'd0);
    drain(10);

    // Core alone: store then load of address 17.
    push(0, 1'b1, 8'd17, 64'h1234);
    push(0, 1'b0, 8'd17, 64'h0);
    drain(10);
    chk("mem17", ref_mem[17], 64'h1234);

    // Continuous contention for 6 cycles.
    push(0, 1'b1, 8'd1, 64'hAAAA_0001);
    push(1, 1'b1, 8'd2, 64'hBBBB_0002);
    drain(10);
    cnt0 = m_cnt;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 8'd1, 64'h0);
      push(1, 1'b0, 8'd2, 64'h0);
    end
    for (int i = 0; i < 6; i++) cyc();
    chk("contention_cnt", 64'(conflict_cnt), 64'(cnt0 + 6));
    q0.delete();
    q1.delete();
    cyc();
    cyc();

    // Loader fill with a core read of address 5 arriving mid-burst.
    for (int i = 0; i < 8; i++) push(1, 1'b1, 8'(i), 64'hF00D_0000 + 64'(i));
    for (int i = 0; i < 7; i++) cyc();
    push(0, 1'b0, 8'd5, 64'h0);
    drain(10);

    // Reset pulsed while an r1 read is in flight.
    push(1, 1'b0, 8'd3, 64'h0);
    drive();
    @(negedge clk);
    eval_check();
    #1 rst_n = 1'b0;
    model_reset();
    q1.delete();
    #1 eval_check();
    drive();
    #1 rst_n = 1'b1;
    @(posedge clk);
    edge_update();
    #1;
    cyc();
    cyc();

    // Randomized traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) != 0)
        push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), {$urandom, $urandom});
      if (q1.size() < 2 && $urandom_range(0, 2) != 0)
        push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), {$urandom, $urandom});
      cyc();
    end
    drain(20);

    // Saturation: long unbroken contention.
    for (int i = 0; i < 36000; i++) begin
      push(0, 1'b0, 8'd1, 64'h0);
      push(1, 1'b0, 8'd2, 64'h0);
    end
    quiet = 1;
    for (int i = 0; i < 69990; i++) cyc();
    quiet = 0;
    for (int i = 0; i < 8; i++) cyc();
    chk("cnt_saturated", 64'(conflict_cnt), 64'hFFFF);
    q0.delete();
    q1.delete();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
